// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array output path.
//   - Default accumulator width and array dimensions.
//   - clog2_min1: ceil(log2(value)), never less than 1 bit.
//     Used to size every counter and pointer.
//   - col_lsb: bit offset of column c inside a packed
//     multi-column bus (column c at c*width).
package systolic_pkg;

  localparam int D_W_ACC_DEF = 64;
  localparam int N_DEF       = 4;
  localparam int M_DEF       = 4;

  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < value) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int col_lsb(input int col, input int width);
    return col * width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO.
// The head word is visible the cycle after it is written; there is no
// empty-bypass path.
// A push while full is accepted only when a pop happens in the same cycle.
// Otherwise the push is ignored, and the caller is expected to detect the
// drop from 'full'.
//
// Ports:
//   clk, rst   clock; asynchronous active-low reset
//   push       write push_data this cycle
//   push_data  word to write
//   pop        remove the head word (ignored when empty)
//   head       current head word (valid when !empty)
//   empty      no words stored
//   full       DEPTH words stored
module sync_fifo
  import systolic_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int AW = clog2_min1(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // The slot freed by a same-cycle pop makes room for the incoming word.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; contents are qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/drain_collector.sv
// Collects the bottom-row drain chains of an N-column systolic array.
// It buffers each column in its own FIFO and re-emits the results as one
// row-major stream: row k, columns 0..N-1.
// m_last marks the M*N-th word of each tile.
//
// The drain chain has no backpressure. A word arriving at a full FIFO is
// dropped, and the sticky overflow flag records the loss.
//
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   in_data      N packed drain words, column c at [c*D_W_ACC +: D_W_ACC]
//   in_valid     per-column drain valid
//   m_data       serialized result word (0 when m_valid is low)
//   m_valid      m_data valid
//   m_ready      downstream accept
//   m_last       final word of a tile
//   overflow     sticky drop indicator
//   clear        synchronous clear of overflow, sel and word_cnt
//   busy         any FIFO non-empty or a tile partly emitted
//
// Handshake:
//   A word transfers on a rising edge where m_valid && m_ready.
//   m_valid depends only on registered state and never waits on m_ready.
//   While m_valid is high and m_ready is low, m_data, m_last and the
//   column select hold their values.
module drain_collector
  import systolic_pkg::*;
#(
  parameter int D_W_ACC    = D_W_ACC_DEF,
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*D_W_ACC-1:0] in_data,
  input  logic [N-1:0]         in_valid,
  output logic [D_W_ACC-1:0]   m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 overflow,
  input  logic                 clear,
  output logic                 busy
);

  localparam int SEL_W = clog2_min1(N);
  localparam int CNT_W = clog2_min1(M * N);

  logic [D_W_ACC-1:0] head [N];
  logic [N-1:0]       empty;
  logic [N-1:0]       full;
  logic [N-1:0]       pop;
  logic [SEL_W-1:0]   sel;
  logic [CNT_W-1:0]   word_cnt;
  logic               xfer;
  logic               drop;
  logic               sel_wrap;
  logic               cnt_wrap;

  for (genvar c = 0; c < N; c++) begin : g_col
    assign pop[c] = xfer && (sel == SEL_W'(c));

    sync_fifo #(
      .W     (D_W_ACC),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_valid[c]),
      .push_data (in_data[col_lsb(c, D_W_ACC) +: D_W_ACC]),
      .pop       (pop[c]),
      .head      (head[c]),
      .empty     (empty[c]),
      .full      (full[c])
    );
  end

  // Strict round-robin: only column sel may be emitted. An empty column
  // stalls the stream even when other columns hold data, which keeps the
  // output in row-major order.
  assign m_valid  = ~empty[sel];
  assign m_data   = m_valid ? head[sel] : '0;
  assign cnt_wrap = (word_cnt == CNT_W'(M * N - 1));
  assign sel_wrap = (sel == SEL_W'(N - 1));
  assign m_last   = m_valid & cnt_wrap;
  assign xfer     = m_valid & m_ready;
  assign busy     = (|(~empty)) | (word_cnt != '0);

  // A push into a full FIFO is lost unless that FIFO pops this same cycle.
  assign drop = |(in_valid & full & ~pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel      <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      // A pop that coincides with clear still happens inside the FIFO;
      // only the sequencing state restarts.
      sel      <= '0;
      word_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | drop;
      if (xfer) begin
        sel      <= sel_wrap ? '0 : sel + 1'b1;
        word_cnt <= cnt_wrap ? '0 : word_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/drain_collector.md
Name: drain_collector

Overview:
- Sits directly downstream of the systolic array's bottom row. It consumes each column's accumulator drain chain (out_data/out_valid of the last PE in every column).
- Buffers each column's words in a per-column FIFO.
- Re-emits the results as one serialized ready/valid stream in row-major order (row k: column 0..N-1), with a last flag on the final word of a tile.
- The drain chain has no backpressure, so the block buffers results and flags any loss.

Parameters:
- D_W_ACC, 64, accumulator word width (matches the PE accumulator width)
- N, 4, number of array columns (drain inputs)
- M, 4, words drained per column per tile (array rows)
- FIFO_DEPTH, 8, per-column FIFO depth; power of two, >= 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_data  in  N*D_W_ACC  column c drain word at bits [c*D_W_ACC +: D_W_ACC]
- in_valid  in  N  column c drain word valid
- m_data  out  D_W_ACC  serialized result word
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accept
- m_last  out  1  high with the final (M*N-th) word of a tile
- overflow  out  1  sticky: a drain word was dropped
- clear  in  1  synchronous; clears overflow and the sequencing counters
- busy  out  1  any FIFO non-empty, or word counter != 0

Behaviour:
- Reset (rst=0, async): FIFO pointers = 0, sel = 0, word_cnt = 0, overflow = 0. Outputs: m_valid = 0, m_last = 0, busy = 0, m_data = 0.
- Write side: on each clk where in_valid[c]=1, the word is pushed into FIFO c.
  - If FIFO c is full and not popped in the same cycle, the word is dropped and overflow sets the next cycle.
  - Full and popped in the same cycle: push is accepted, no overflow.
- FIFO is show-ahead. The head is visible the cycle after the write. There is no empty-bypass.
  - Minimum latency in_valid -> m_valid is 1 cycle.
- Read side:
  - m_valid = !empty[sel]; m_data = head[sel].
  - Both are driven from registers only, with no combinational path from in_*.
- Handshake: transfer occurs when m_valid & m_ready.
  - On transfer: pop FIFO sel; sel = (sel == N-1) ? 0 : sel+1; word_cnt = (word_cnt == M*N-1) ? 0 : word_cnt+1.
  - m_valid high with m_ready low: m_data, m_last and sel are held stable.
  - m_valid never waits on m_ready.
- m_last = m_valid & (word_cnt == M*N-1).
- Strict round-robin: if column sel is empty, the block stalls even when other columns hold data. This preserves row-major order.
- clear:
  - Resets sel, word_cnt and overflow the next cycle.
  - FIFO contents are retained.
  - If clear and a transfer coincide, clear wins: counters go to 0 and the pop still happens.
- Counter widths are clog2(N) and clog2(M*N), with a minimum of 1 bit. FIFO count width is clog2(FIFO_DEPTH)+1.
- Reset asserted mid-tile: all buffered data is discarded and m_valid drops asynchronously.

Decomposition:
- Shared package systolic_pkg holds:
  - default D_W_ACC, N, M
  - a clog2 constant function used for all counter and pointer widths
  - the in_data slicing convention (column c at c*D_W_ACC)
- One sub-module, sync_fifo (show-ahead, async active-low reset, simultaneous push/pop legal when full), instantiated N times in a generate loop.
- Sequencer and output mux stay in drain_collector.

Test Plan:
- Reset, full tile, no backpressure:
  - Stimulus: rst low, then release. Drive each column c with 4 words 0x100*c+k (k = 0..3) over 4 cycles, all columns together. m_ready = 1.
  - Expected: 16 words in order 0x000, 0x100, 0x200, 0x300, 0x001, ..., 0x303. m_last high only on 0x303. busy falls after the last transfer.
- Backpressure hold:
  - Stimulus: same tile; m_ready toggles 1,0,0,1.
  - Expected: m_data/m_last are stable through every stall cycle; order is unchanged; no overflow.
- Skewed columns:
  - Stimulus: column 0 drains 3 cycles after columns 1-3.
  - Expected: first m_valid only after column 0's first word arrives; output is still row-major.
- Overflow:
  - Stimulus: FIFO_DEPTH = 8, m_ready = 0, column 2 pushed 9 times.
  - Expected: overflow = 1 after the 9th push; the first 8 words are retained. clear pulse -> overflow = 0, sel = 0.
- Full plus pop:
  - Stimulus: column 0 FIFO full and sel = 0; m_ready = 1 and in_valid[0] = 1 in the same cycle.
  - Expected: push is accepted, overflow stays 0, FIFO count stays 8.
- Async reset mid-tile:
  - Stimulus: assert rst after 5 transfers.
  - Expected: m_valid = 0 immediately. After release, a fresh tile outputs from column 0, word 0, with correct m_last.
